reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Architectural register file with per-register rename table; the responder side of the reservation-station rename/operand query protocol. Each query cycle it records the new instruction's destination rename (rd → ROB tag) and returns, one cycle later, each requested source's current value or producing ROB tag. ROB commits write values and release renames; a flush drops all pending renames.

## Interface
- REG_NUM, 32, architectural registers (x0 hard-wired zero)
- TAG_W, 4, ROB tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = hold all state and outputs
- rename_need  in  1  query/rename request from RS
- rename_need_ins_is_simple  in  1  LUI/AUIPC/JAL: rename rd only, no response
- rename_need_ins_is_branch_or_store  in  1  no rd; read sources only
- rename_need_id  in  TAG_W  RS slot to echo back
- operand_1_flag / operand_2_flag  in  1  source operand requested
- operand_1_reg / operand_2_reg  in  5  source register index
- new_ins_rd_rename  in  TAG_W  ROB tag of new instruction
- new_ins_rd  in  5  destination register
- commit_flag  in  1  ROB commit writes a register
- commit_reg  in  5  committed rd
- commit_rename  in  TAG_W  ROB tag of committing instruction
- commit_value  in  32  committed result
- flush  in  1  misprediction flush
- rename_finish  out  1  response valid (1-cycle pulse)
- rename_finish_id  out  TAG_W  echoed rename_need_id
- operand_1_busy / operand_2_busy  out  1  source awaiting producer
- operand_1_rename / operand_2_rename  out  TAG_W  producer ROB tag when busy
- operand_1_data_from_reg / operand_2_data_from_reg  out  32  value when not busy

## Operation
- State per register: value[31:0], busy, tag[TAG_W-1:0]. x0: busy always 0, value always 0.
- Query (rename_need=1, not simple): respond next cycle with rename_finish=1, rename_finish_id=rename_need_id. Per operand: flag=0 or reg=x0 → busy=0, data=0; else busy=busy[r], rename=tag[r], data=value[r].
- Source reads see state before this query's own rd rename (addi x1,x1,1 reads old x1 mapping).
- Commit bypass: commit in query cycle with commit_reg==operand reg, busy, tag==commit_rename → respond busy=0, data=commit_value.
- Rename: rename_need=1, branch_or_store=0, new_ins_rd≠0 → busy[rd]<=1, tag[rd]<=new_ins_rd_rename. Applies for simple instructions too.
- Commit: commit_flag, commit_reg≠0 → value<=commit_value; busy<=0 only if tag==commit_rename and no same-cycle rename of that register. Same-cycle rename of same reg wins busy/tag.
- Flush: all busy<=0, rename_finish<=0, rename ignored that cycle; commit value write still applied; values otherwise preserved.
- rdy=0: no state change, outputs hold; inputs that cycle ignored.

## Timing
- Response latency exactly 1 cycle; rename_finish high 1 cycle per query; back-to-back queries give back-to-back responses, each reflecting predecessor's rename.
- Simple queries: rename_finish=0 next cycle.
- Reset: all value=0, busy=0, tag=0; rename_finish=0, rename_finish_id=0, operand busy=0, rename=0, data=0.
- No backpressure: RS must accept every response.

## Structure
- Shared package: REG_NUM, TAG_W, x0 index constant.
- One sub-module natural: rename_read_port (one operand lookup with x0/flag/commit bypass), instantiated twice.

## Test plan
- Reset, query x5/x6 → busy=0, data=0, rename_finish_id echoed.
- Rename x3→tag 7, next query reads x3 → busy=1, rename=7; commit x3 tag 7 value 0x55 → later read busy=0 data=0x55.
- Rename x3→7 then x3→9; commit tag 7 value 0x11 → x3 stays busy tag 9, value 0x11.
- Query x4 (busy tag 2) same cycle as commit tag 2 value 0xABCD → busy=0 data=0xABCD.
- Rename x8→5; flush same cycle as commit x9=0x77 → x8 not busy, x9=0x77, no rename_finish.
- Simple query rd=x1 → no response, x1 busy; rd=x0 / branch query → no rename, x0 reads 0.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the architectural register file / rename table.
package reg_rename_file_pkg;

    localparam int REG_NUM   = 32;
    localparam int TAG_W     = 4;
    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = $clog2(REG_NUM);

    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

endpackage

// File: rtl/rename_read_port.sv
// One source-operand lookup: handles the unrequested/x0 case and forwards a
// same-cycle commit of the producing ROB entry so the consumer sees the value.
module rename_read_port
    import reg_rename_file_pkg::*;
(
    input  logic                 op_flag,
    input  logic [REG_IDX_W-1:0] op_reg,
    input  logic                 reg_busy,
    input  logic [TAG_W-1:0]     reg_tag,
    input  logic [DATA_W-1:0]    reg_value,
    input  logic                 commit_flag,
    input  logic [REG_IDX_W-1:0] commit_reg,
    input  logic [TAG_W-1:0]     commit_rename,
    input  logic [DATA_W-1:0]    commit_value,
    output logic                 busy,
    output logic [TAG_W-1:0]     rename,
    output logic [DATA_W-1:0]    data
);

    // Select current mapping, or the committing value when the producer retires now.
    always_comb begin
        busy   = 1'b0;
        rename = '0;
        data   = '0;
        if (op_flag && (op_reg != X0_IDX)) begin
            if (commit_flag && (commit_reg == op_reg) && reg_busy && (reg_tag == commit_rename)) begin
                data = commit_value;
            end else begin
                busy   = reg_busy;
                rename = reg_tag;
                data   = reg_value;
            end
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename table. Answers RS
// operand queries one cycle later, records destination renames, applies ROB
// commits and drops all pending renames on a flush.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rename_need,
    input  logic                 rename_need_ins_is_simple,
    input  logic                 rename_need_ins_is_branch_or_store,
    input  logic [TAG_W-1:0]     rename_need_id,
    input  logic                 operand_1_flag,
    input  logic [REG_IDX_W-1:0] operand_1_reg,
    input  logic                 operand_2_flag,
    input  logic [REG_IDX_W-1:0] operand_2_reg,
    input  logic [TAG_W-1:0]     new_ins_rd_rename,
    input  logic [REG_IDX_W-1:0] new_ins_rd,
    input  logic                 commit_flag,
    input  logic [REG_IDX_W-1:0] commit_reg,
    input  logic [TAG_W-1:0]     commit_rename,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic                 flush,
    output logic                 rename_finish,
    output logic [TAG_W-1:0]     rename_finish_id,
    output logic                 operand_1_busy,
    output logic [TAG_W-1:0]     operand_1_rename,
    output logic [DATA_W-1:0]    operand_1_data_from_reg,
    output logic                 operand_2_busy,
    output logic [TAG_W-1:0]     operand_2_rename,
    output logic [DATA_W-1:0]    operand_2_data_from_reg
);

    logic [DATA_W-1:0] value_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic              query_p0;
    logic              rename_en_p0;
    logic              commit_wr_p0;
    logic              commit_clr_p0;

    logic              op1_busy_p0;
    logic [TAG_W-1:0]  op1_rename_p0;
    logic [DATA_W-1:0] op1_data_p0;
    logic              op2_busy_p0;
    logic [TAG_W-1:0]  op2_rename_p0;
    logic [DATA_W-1:0] op2_data_p0;

    logic              vld_p1;
    logic [TAG_W-1:0]  id_p1;
    logic              op1_busy_p1;
    logic [TAG_W-1:0]  op1_rename_p1;
    logic [DATA_W-1:0] op1_data_p1;
    logic              op2_busy_p1;
    logic [TAG_W-1:0]  op2_rename_p1;
    logic [DATA_W-1:0] op2_data_p1;

    // ---- stage p0: decode request, look up sources against pre-rename state ----
    assign query_p0     = rename_need && !rename_need_ins_is_simple && !flush;
    assign rename_en_p0 = rename_need && !rename_need_ins_is_branch_or_store
                          && (new_ins_rd != X0_IDX) && !flush;
    assign commit_wr_p0 = commit_flag && (commit_reg != X0_IDX);
    // A commit only frees the register if it is still the newest producer and
    // is not being renamed again this same cycle.
    assign commit_clr_p0 = commit_wr_p0 && busy_q[commit_reg]
                           && (tag_q[commit_reg] == commit_rename)
                           && !(rename_en_p0 && (new_ins_rd == commit_reg));

    rename_read_port u_read_1 (
        .op_flag       (operand_1_flag),
        .op_reg        (operand_1_reg),
        .reg_busy      (busy_q[operand_1_reg]),
        .reg_tag       (tag_q[operand_1_reg]),
        .reg_value     (value_q[operand_1_reg]),
        .commit_flag   (commit_flag),
        .commit_reg    (commit_reg),
        .commit_rename (commit_rename),
        .commit_value  (commit_value),
        .busy          (op1_busy_p0),
        .rename        (op1_rename_p0),
        .data          (op1_data_p0)
    );

    rename_read_port u_read_2 (
        .op_flag       (operand_2_flag),
        .op_reg        (operand_2_reg),
        .reg_busy      (busy_q[operand_2_reg]),
        .reg_tag       (tag_q[operand_2_reg]),
        .reg_value     (value_q[operand_2_reg]),
        .commit_flag   (commit_flag),
        .commit_reg    (commit_reg),
        .commit_rename (commit_rename),
        .commit_value  (commit_value),
        .busy          (op2_busy_p0),
        .rename        (op2_rename_p0),
        .data          (op2_data_p0)
    );

    // Architectural state update: commit value, busy/tag bookkeeping, flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_wr_p0) begin
                value_q[commit_reg] <= commit_value;
            end
            if (flush) begin
                busy_q <= '0;
            end else begin
                if (commit_clr_p0) begin
                    busy_q[commit_reg] <= 1'b0;
                end
                if (rename_en_p0) begin
                    busy_q[new_ins_rd] <= 1'b1;
                    tag_q[new_ins_rd]  <= new_ins_rd_rename;
                end
            end
        end
    end

    // ---- stage p1: registered response to the RS ----
    // Register the query response; payload holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            id_p1         <= '0;
            op1_busy_p1   <= 1'b0;
            op1_rename_p1 <= '0;
            op1_data_p1   <= '0;
            op2_busy_p1   <= 1'b0;
            op2_rename_p1 <= '0;
            op2_data_p1   <= '0;
        end else if (rdy) begin
            vld_p1 <= query_p0;
            if (query_p0) begin
                id_p1         <= rename_need_id;
                op1_busy_p1   <= op1_busy_p0;
                op1_rename_p1 <= op1_rename_p0;
                op1_data_p1   <= op1_data_p0;
                op2_busy_p1   <= op2_busy_p0;
                op2_rename_p1 <= op2_rename_p0;
                op2_data_p1   <= op2_data_p0;
            end
        end
    end

    assign rename_finish           = vld_p1;
    assign rename_finish_id        = id_p1;
    assign operand_1_busy          = op1_busy_p1;
    assign operand_1_rename        = op1_rename_p1;
    assign operand_1_data_from_reg = op1_data_p1;
    assign operand_2_busy          = op2_busy_p1;
    assign operand_2_rename        = op2_rename_p1;
    assign operand_2_data_from_reg = op2_data_p1;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed + short random bench for reg_rename_file with a queue scoreboard.
module tb_reg_rename_file;
    import reg_rename_file_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, rdy;
    logic                 rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store;
    logic [TAG_W-1:0]     rename_need_id;
    logic                 operand_1_flag, operand_2_flag;
    logic [REG_IDX_W-1:0] operand_1_reg, operand_2_reg;
    logic [TAG_W-1:0]     new_ins_rd_rename;
    logic [REG_IDX_W-1:0] new_ins_rd;
    logic                 commit_flag;
    logic [REG_IDX_W-1:0] commit_reg;
    logic [TAG_W-1:0]     commit_rename;
    logic [DATA_W-1:0]    commit_value;
    logic                 flush;
    logic                 rename_finish;
    logic [TAG_W-1:0]     rename_finish_id;
    logic                 operand_1_busy, operand_2_busy;
    logic [TAG_W-1:0]     operand_1_rename, operand_2_rename;
    logic [DATA_W-1:0]    operand_1_data_from_reg, operand_2_data_from_reg;

    reg_rename_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rename_need(rename_need),
        .rename_need_ins_is_simple(rename_need_ins_is_simple),
        .rename_need_ins_is_branch_or_store(rename_need_ins_is_branch_or_store),
        .rename_need_id(rename_need_id),
        .operand_1_flag(operand_1_flag), .operand_1_reg(operand_1_reg),
        .operand_2_flag(operand_2_flag), .operand_2_reg(operand_2_reg),
        .new_ins_rd_rename(new_ins_rd_rename), .new_ins_rd(new_ins_rd),
        .commit_flag(commit_flag), .commit_reg(commit_reg),
        .commit_rename(commit_rename), .commit_value(commit_value),
        .flush(flush),
        .rename_finish(rename_finish), .rename_finish_id(rename_finish_id),
        .operand_1_busy(operand_1_busy), .operand_1_rename(operand_1_rename),
        .operand_1_data_from_reg(operand_1_data_from_reg),
        .operand_2_busy(operand_2_busy), .operand_2_rename(operand_2_rename),
        .operand_2_data_from_reg(operand_2_data_from_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]  id;
        logic              b1;
        logic [TAG_W-1:0]  r1;
        logic [DATA_W-1:0] d1;
        logic              b2;
        logic [TAG_W-1:0]  r2;
        logic [DATA_W-1:0] d2;
    } exp_t;

    exp_t sb[$];

    logic [DATA_W-1:0] m_value [REG_NUM];
    logic [TAG_W-1:0]  m_tag   [REG_NUM];
    logic              m_busy  [REG_NUM];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1;
        rename_need = 0; rename_need_ins_is_simple = 0; rename_need_ins_is_branch_or_store = 0;
        rename_need_id = '0;
        operand_1_flag = 0; operand_1_reg = '0; operand_2_flag = 0; operand_2_reg = '0;
        new_ins_rd_rename = '0; new_ins_rd = '0;
        commit_flag = 0; commit_reg = '0; commit_rename = '0; commit_value = '0;
        flush = 0;
    endtask

    // Expected lookup of one source against the model's pre-edge state.
    task automatic predict_op(input logic f, input logic [REG_IDX_W-1:0] r,
                              output logic b, output logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        b = 0; t = '0; d = '0;
        if (f && r != 0) begin
            if (commit_flag && commit_reg == r && m_busy[r] && m_tag[r] == commit_rename) begin
                d = commit_value;
            end else begin
                b = m_busy[r]; t = m_tag[r]; d = m_value[r];
            end
        end
    endtask

    task automatic model_update();
        logic clr, ren;
        if (!rdy) return;
        clr = commit_flag && commit_reg != 0 && m_busy[commit_reg] && m_tag[commit_reg] == commit_rename;
        ren = rename_need && !rename_need_ins_is_branch_or_store && new_ins_rd != 0 && !flush;
        if (commit_flag && commit_reg != 0) m_value[commit_reg] = commit_value;
        if (flush) begin
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
        end else begin
            if (clr && !(ren && new_ins_rd == commit_reg)) m_busy[commit_reg] = 1'b0;
            if (ren) begin
                m_busy[new_ins_rd] = 1'b1;
                m_tag[new_ins_rd]  = new_ins_rd_rename;
            end
        end
    endtask

    // One clock: predict, push, clock, compare response, return to idle inputs.
    task automatic cyc();
        exp_t e;
        logic exp_fin;
        if (rdy && rename_need && !rename_need_ins_is_simple && !flush) begin
            e.id = rename_need_id;
            predict_op(operand_1_flag, operand_1_reg, e.b1, e.r1, e.d1);
            predict_op(operand_2_flag, operand_2_reg, e.b2, e.r2, e.d2);
            sb.push_back(e);
        end
        @(posedge clk);
        model_update();
        #1;
        exp_fin = (sb.size() != 0);
        chk("rename_finish", {31'd0, rename_finish}, {31'd0, exp_fin});
        if (exp_fin) begin
            e = sb.pop_front();
            if (rename_finish === 1'b1) begin
                chk("finish_id", {28'd0, rename_finish_id}, {28'd0, e.id});
                chk("op1_busy", {31'd0, operand_1_busy}, {31'd0, e.b1});
                chk("op1_data", operand_1_data_from_reg, e.d1);
                if (e.b1) chk("op1_rename", {28'd0, operand_1_rename}, {28'd0, e.r1});
                chk("op2_busy", {31'd0, operand_2_busy}, {31'd0, e.b2});
                chk("op2_data", operand_2_data_from_reg, e.d2);
                if (e.b2) chk("op2_rename", {28'd0, operand_2_rename}, {28'd0, e.r2});
            end
        end
        idle();
    endtask

    task automatic query(input logic [TAG_W-1:0] id,
                         input logic f1, input logic [4:0] r1,
                         input logic f2, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [TAG_W-1:0] rtag);
        rename_need = 1; rename_need_id = id;
        operand_1_flag = f1; operand_1_reg = r1;
        operand_2_flag = f2; operand_2_reg = r2;
        new_ins_rd = rd; new_ins_rd_rename = rtag;
    endtask

    task automatic commit(input logic [4:0] r, input logic [TAG_W-1:0] t, input logic [31:0] v);
        commit_flag = 1; commit_reg = r; commit_rename = t; commit_value = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < REG_NUM; i++) begin
            m_value[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_finish", {31'd0, rename_finish}, 32'd0);
        chk("rst_id", {28'd0, rename_finish_id}, 32'd0);
        chk("rst_op1_busy", {31'd0, operand_1_busy}, 32'd0);
        chk("rst_op1_rename", {28'd0, operand_1_rename}, 32'd0);
        chk("rst_op1_data", operand_1_data_from_reg, 32'd0);
        chk("rst_op2_busy", {31'd0, operand_2_busy}, 32'd0);
        chk("rst_op2_data", operand_2_data_from_reg, 32'd0);
        rst = 1'b0;

        // Plain query of untouched registers
        query(4'd3, 1, 5'd5, 1, 5'd6, 5'd0, 4'd0); cyc();

        // Rename x3->7, read it, commit it, read value
        query(4'd1, 0, 5'd0, 0, 5'd0, 5'd3, 4'd7); cyc();
        query(4'd2, 1, 5'd3, 0, 5'd0, 5'd0, 4'd0); cyc();
        commit(5'd3, 4'd7, 32'h55); cyc();
        query(4'd4, 1, 5'd3, 1, 5'd3, 5'd0, 4'd0); cyc();

        // addi x3,x3 style: reads old mapping; back-to-back sees predecessor
        query(4'd5, 1, 5'd3, 0, 5'd0, 5'd3, 4'd7); cyc();
        query(4'd6, 1, 5'd3, 0, 5'd0, 5'd3, 4'd9); cyc();
        commit(5'd3, 4'd7, 32'h11); cyc();
        query(4'd7, 1, 5'd3, 0, 5'd0, 5'd0, 4'd0); cyc();

        // Commit bypass into a same-cycle query
        query(4'd8, 0, 5'd0, 0, 5'd0, 5'd4, 4'd2); cyc();
        query(4'd9, 0, 5'd0, 1, 5'd4, 5'd0, 4'd0); commit(5'd4, 4'd2, 32'hABCD); cyc();
        query(4'd10, 1, 5'd4, 0, 5'd0, 5'd0, 4'd0); cyc();

        // Flush drops rename and response, keeps commit value
        query(4'd11, 0, 5'd0, 0, 5'd0, 5'd10, 4'd1); cyc();
        query(4'd12, 1, 5'd10, 0, 5'd0, 5'd8, 4'd5); commit(5'd9, 4'd0, 32'h77); flush = 1; cyc();
        query(4'd13, 1, 5'd8, 1, 5'd9, 5'd0, 4'd0); cyc();
        query(4'd14, 1, 5'd10, 1, 5'd3, 5'd0, 4'd0); cyc();

        // Simple instruction renames rd without responding
        query(4'd15, 1, 5'd2, 0, 5'd0, 5'd1, 4'd6); rename_need_ins_is_simple = 1; cyc();
        query(4'd0, 1, 5'd1, 0, 5'd0, 5'd0, 4'd0); cyc();

        // rd=x0 and branch/store never rename
        query(4'd1, 1, 5'd0, 0, 5'd0, 5'd0, 4'd3); cyc();
        query(4'd2, 1, 5'd2, 1, 5'd0, 5'd2, 4'd4); rename_need_ins_is_branch_or_store = 1; cyc();
        query(4'd3, 1, 5'd2, 1, 5'd0, 5'd0, 4'd0); cyc();

        // Same-cycle rename and commit of one register: rename wins busy/tag
        query(4'd4, 0, 5'd0, 0, 5'd0, 5'd3, 4'd9); cyc();
        query(4'd5, 0, 5'd0, 0, 5'd0, 5'd3, 4'd10); commit(5'd3, 4'd9, 32'h22); cyc();
        query(4'd6, 1, 5'd3, 0, 5'd0, 5'd0, 4'd0); cyc();

        // rdy low: everything ignored, outputs hold
        cyc();
        query(4'd7, 1, 5'd5, 0, 5'd0, 5'd5, 4'd1); commit(5'd6, 4'd0, 32'h99); rdy = 0; cyc();
        query(4'd8, 1, 5'd5, 1, 5'd6, 5'd0, 4'd0); cyc();

        // Short random mix against the model
        for (int n = 0; n < 40; n++) begin
            rename_need = ($urandom_range(0, 3) != 0);
            rename_need_ins_is_simple = ($urandom_range(0, 7) == 0);
            rename_need_ins_is_branch_or_store = ($urandom_range(0, 5) == 0);
            rename_need_id = 4'($urandom);
            operand_1_flag = $urandom_range(0, 1); operand_1_reg = 5'($urandom_range(0, 7));
            operand_2_flag = $urandom_range(0, 1); operand_2_reg = 5'($urandom_range(0, 7));
            new_ins_rd = 5'($urandom_range(0, 7)); new_ins_rd_rename = 4'($urandom);
            commit_flag = $urandom_range(0, 1); commit_reg = 5'($urandom_range(0, 7));
            commit_rename = m_busy[commit_reg] && ($urandom_range(0, 2) != 0) ? m_tag[commit_reg] : 4'($urandom);
            commit_value = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
